// File: rtl/mem_access_if.sv
// ---------------------------------------------------------------------------
// mem_access_if -- data-memory bus between the RV32I memory stage and dmem.
//
// Signals
//   dmem_req     master->slave  bus request
//   dmem_we      master->slave  1 = write
//   dmem_addr    master->slave  word-aligned address
//   dmem_be      master->slave  byte enables
//   dmem_wdata   master->slave  lane-replicated store data
//   dmem_gnt     slave->master  request accepted this cycle
//   dmem_rvalid  slave->master  read data valid
//   dmem_rdata   slave->master  read data
// ---------------------------------------------------------------------------
interface mem_access_if #(
   parameter int XLEN = 32
);
   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [3:0]      dmem_be;
   logic [XLEN-1:0] dmem_wdata;
   logic            dmem_gnt;
   logic            dmem_rvalid;
   logic [XLEN-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_gnt, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_gnt, dmem_rvalid, dmem_rdata
   );
endinterface

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access -- RV32I memory stage between execute and write_back.
//
// Runs loads/stores over a req/gnt/rvalid data-memory bus, stalls the pipe
// while an access is outstanding, lane-aligns load data and registers the
// MEM/WB bundle. Also exposes MEM-stage forwarding info.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   *_ex                EX/MEM bundle; held by upstream while stall_mem=1
//   stall_mem           combinational stall to upstream
//   dmem (master)       data-memory bus (see mem_access_if)
//   *_mem / *_mem_wb    registered MEM/WB bundle to write_back
//   rd_mem_fw, data_mem_fw, we_mem   combinational forwarding info
//   misalign_exc        one-cycle misaligned-access pulse
//
// Build option
//   MEM_MISALIGN_TRAP_EN  defined: misaligned H/W accesses issue no request
//                         and raise misalign_exc. Undefined: offending low
//                         address bits are forced to 0, misalign_exc tied 0.
// ---------------------------------------------------------------------------
module mem_access #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               valid_ex,
   input  logic [2:0]         funct3_ex,
   input  logic               mem_rd_ex,
   input  logic               mem_wr_ex,
   input  logic               gpr_en_ex,
   input  logic               gpr_we_ex,
   input  logic [RADDR_W-1:0] addr_rd_ex,
   input  logic [XLEN-1:0]    alu_res_ex,
   input  logic [XLEN-1:0]    store_data_ex,
   output logic               stall_mem,
   mem_access_if.master       dmem,
   output logic [2:0]         funct3_mem_wb,
   output logic               mem_mem_wb,
   output logic               gpr_en_mem,
   output logic               gpr_we_mem,
   output logic [RADDR_W-1:0] addr_rd_mem,
   output logic [XLEN-1:0]    data_rd_mem,
   output logic [XLEN-1:0]    data_rd_mem_load,
   output logic [RADDR_W-1:0] rd_mem_fw,
   output logic [XLEN-1:0]    data_mem_fw,
   output logic               we_mem,
   output logic               misalign_exc
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t          state_q, state_d;
   logic            mem_op_raw;
   logic            mem_op;
   logic            mem_retire;
   logic            bus_req;
   logic            wb_load;
   logic [1:0]      off;
   logic [XLEN-1:0] load_data;

   assign mem_op_raw = valid_ex & (mem_rd_ex | mem_wr_ex);

`ifdef MEM_MISALIGN_TRAP_EN
   logic misaligned;

   always_comb begin
      misaligned = 1'b0;
      case (funct3_ex[1:0])
         2'b01:   misaligned = alu_res_ex[0];
         2'b10:   misaligned = |alu_res_ex[1:0];
         default: misaligned = 1'b0;
      endcase
   end

   assign mem_op = mem_op_raw & ~misaligned;
`else
   assign mem_op = mem_op_raw;
`endif

   // Byte offset with the bits that cannot be legal for the access size
   // cleared; for aligned accesses this is simply addr[1:0].
   always_comb begin
      off = 2'b00;
      case (funct3_ex[1:0])
         2'b00:   off = alu_res_ex[1:0];
         2'b01:   off = {alu_res_ex[1], 1'b0};
         default: off = 2'b00;
      endcase
   end

   always_comb begin
      dmem.dmem_be    = 4'b1111;
      dmem.dmem_wdata = store_data_ex;
      case (funct3_ex[1:0])
         2'b00: begin
            dmem.dmem_be    = 4'b0001 << off;
            dmem.dmem_wdata = {4{store_data_ex[7:0]}};
         end
         2'b01: begin
            dmem.dmem_be    = 4'b0011 << off;
            dmem.dmem_wdata = {2{store_data_ex[15:0]}};
         end
         default: begin
            dmem.dmem_be    = 4'b1111;
            dmem.dmem_wdata = store_data_ex;
         end
      endcase
   end

   assign dmem.dmem_addr = {alu_res_ex[XLEN-1:2], 2'b00};
   assign dmem.dmem_req  = bus_req;
   assign dmem.dmem_we   = bus_req & mem_wr_ex;
   assign load_data      = dmem.dmem_rdata >> {off, 3'b000};

   // IDLE and REQ behave identically once a request is up: IDLE raises req
   // combinationally so a first-cycle gnt costs no extra cycle.
   always_comb begin
      state_d    = state_q;
      bus_req    = 1'b0;
      mem_retire = 1'b0;
      case (state_q)
         IDLE, REQ: begin
            if (mem_op) begin
               bus_req = 1'b1;
               if (dmem.dmem_gnt) begin
                  if (mem_wr_ex) begin
                     mem_retire = 1'b1;
                     state_d    = IDLE;
                  end else begin
                     state_d = RESP;
                  end
               end else begin
                  state_d = REQ;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RESP: begin
            if (dmem.dmem_rvalid) begin
               mem_retire = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   assign stall_mem = mem_op & ~mem_retire;
   // A trapped misaligned op (mem_op_raw & ~mem_op) never loads MEM/WB.
   assign wb_load   = valid_ex & (mem_op ? mem_retire : ~mem_op_raw);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         funct3_mem_wb    <= '0;
         mem_mem_wb       <= 1'b0;
         gpr_en_mem       <= 1'b0;
         gpr_we_mem       <= 1'b0;
         addr_rd_mem      <= '0;
         data_rd_mem      <= '0;
         data_rd_mem_load <= '0;
      end else if (wb_load) begin
         funct3_mem_wb    <= funct3_ex;
         mem_mem_wb       <= mem_rd_ex;
         gpr_en_mem       <= gpr_en_ex;
         gpr_we_mem       <= gpr_we_ex & ~mem_wr_ex;
         addr_rd_mem      <= addr_rd_ex;
         data_rd_mem      <= alu_res_ex;
         data_rd_mem_load <= load_data;
      end else begin
         gpr_en_mem <= 1'b0;
         gpr_we_mem <= 1'b0;
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign_exc <= 1'b0;
      else        misalign_exc <= mem_op_raw & misaligned;
   end
`else
   assign misalign_exc = 1'b0;
`endif

   assign rd_mem_fw   = addr_rd_ex;
   assign data_mem_fw = alu_res_ex;
   assign we_mem      = valid_ex & gpr_we_ex & ~mem_rd_ex;

endmodule
